// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port registered-read RAM between
// the instruction-fetch port (I) and the load/store port (D).
module ram_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_ack,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        own_q, own_d;
  logic        own_we_q, own_we_d;
  logic        last_q, last_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        resp;
  logic        i_elig;
  logic        d_elig;
  logic        pick_d;

  // owner/last are 1 for port D; the owner's req is masked in RESP
  assign resp   = (state_q == S_RESP);
  assign i_elig = i_req & ~(resp & ~own_q);
  assign d_elig = d_req & ~(resp & own_q);
  assign pick_d = (i_elig & d_elig)
                ? (FIXED_PRI | ~last_q)
                : d_elig;

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    own_we_d = own_we_q;
    last_d   = last_q;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      S_ACCESS: state_d = S_RESP;
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (i_elig | d_elig) begin
          state_d  = S_ACCESS;
          cs_d     = 1'b1;
          we_d     = pick_d & d_we;
          addr_d   = pick_d ? d_addr : i_addr;
          wdata_d  = pick_d ? d_wdata : 64'd0;
          own_d    = pick_d;
          own_we_d = pick_d & d_we;
          last_d   = pick_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      own_q    <= 1'b0;
      own_we_q <= 1'b0;
      last_q   <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      own_we_q <= own_we_d;
      last_q   <= last_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_ack   = resp & ~own_q;
  assign d_ack   = resp & own_q;
  assign i_rdata = i_ack ? mem_rdata : 64'd0;
  assign d_rdata = (d_ack & ~own_we_q) ? mem_rdata : 64'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench with a byte-array RAM and a
// reference memory; random and directed traffic on both ports.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [63:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic        i_ack, d_ack, mem_cs, mem_we;
  logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  ram_arbiter #(.FIXED_PRI(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic        p_i_req = 0, p_d_req = 0;
  logic        p_d_we = 0;
  logic [63:0] p_i_addr = 64'h40, p_d_addr = 64'h48;
  logic [63:0] p_d_wdata = 0, p_mem_rdata = 0;
  logic        p_i_ack, p_d_ack, p_cs, p_we;
  logic [63:0] p_i_rdata, p_d_rdata, p_addr, p_wdata;

  ram_arbiter #(.FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_req(p_i_req), .i_addr(p_i_addr),
    .i_ack(p_i_ack), .i_rdata(p_i_rdata),
    .d_req(p_d_req), .d_we(p_d_we),
    .d_addr(p_d_addr), .d_wdata(p_d_wdata),
    .d_ack(p_d_ack), .d_rdata(p_d_rdata),
    .mem_cs(p_cs), .mem_we(p_we),
    .mem_addr(p_addr), .mem_wdata(p_wdata),
    .mem_rdata(p_mem_rdata)
  );

  // test RAM: byte array, registered read
  logic [7:0]  ram [1024];
  logic [7:0]  refm [1024];
  logic [63:0] rd_q;
  logic        bd_clr = 1, bd_we = 0;
  logic [9:0]  bd_addr = 0;
  logic [63:0] bd_data = 0;
  assign mem_rdata = rd_q;

  function automatic logic [63:0] ram_rd(input logic [63:0] a);
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++)
      r[8*k +: 8] = ram[10'(a[9:0] + 10'(k))];
    return r;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++)
      r[8*k +: 8] = refm[10'(a[9:0] + 10'(k))];
    return r;
  endfunction

  function automatic void ref_wr(input logic [63:0] a,
                                 input logic [63:0] v);
    for (int k = 0; k < 8; k++)
      refm[10'(a[9:0] + 10'(k))] = v[8*k +: 8];
  endfunction

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int k = 0; k < 1024; k++) ram[k] <= 8'h00;
    end else if (bd_we) begin
      for (int k = 0; k < 8; k++)
        ram[10'(bd_addr + 10'(k))] <= bd_data[8*k +: 8];
    end else if (mem_cs) begin
      if (mem_we) begin
        for (int k = 0; k < 8; k++)
          ram[10'(mem_addr[9:0] + 10'(k))] <= mem_wdata[8*k +: 8];
      end else begin
        rd_q <= ram_rd(mem_addr);
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [63:0] iq[$];
  logic [63:0] dq[$];
  int          order_q[$];
  int          i_acks = 0, d_acks = 0, n_iss = 0;
  logic        prev_cs = 0;

  always @(negedge clk) begin
    chk("ack_excl", 64'(i_ack & d_ack), 64'd0);
    chk("p_ack_excl", 64'(p_i_ack & p_d_ack), 64'd0);
    chk("cs_consec", 64'(prev_cs & mem_cs), 64'd0);
    prev_cs <= mem_cs;
    if (mem_cs && mem_we) begin
      chk("wr_addr", mem_addr, d_addr);
      chk("wr_data", mem_wdata, d_wdata);
    end
    if (mem_cs && !mem_we)
      chk("rd_addr", 64'((i_req && mem_addr == i_addr) ||
          (d_req && !d_we && mem_addr == d_addr)), 64'd1);
    if (i_ack) begin
      i_acks++;
      order_q.push_back(0);
      chk("i_addr_hold", mem_addr, i_addr);
      if (iq.size() == 0) chk("i_unexp_ack", 64'd1, 64'd0);
      else chk("i_rdata", i_rdata, iq.pop_front());
    end else begin
      chk("i_rdata_idle", i_rdata, 64'd0);
    end
    if (d_ack) begin
      d_acks++;
      order_q.push_back(1);
      chk("d_addr_hold", mem_addr, d_addr);
      if (dq.size() == 0) chk("d_unexp_ack", 64'd1, 64'd0);
      else chk("d_rdata", d_rdata, dq.pop_front());
    end else begin
      chk("d_rdata_idle", d_rdata, 64'd0);
    end
  end

  // tasks are entered just after a rising edge
  task automatic do_i(input logic [63:0] a, output int ac);
    bit got = 0;
    i_addr = a;
    i_req  = 1;
    iq.push_back(ref_rd(a));
    n_iss++;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = i_ack;
    end
    ac = cyc;
    if (!got) chk("i_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    i_req = 0;
  endtask

  task automatic do_d(input logic we, input logic [63:0] a,
                      input logic [63:0] wd, output int ac);
    bit got = 0;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1;
    if (we) begin
      ref_wr(a, wd);
      dq.push_back(64'd0);
    end else begin
      dq.push_back(ref_rd(a));
    end
    n_iss++;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = d_ack;
    end
    ac = cyc;
    if (!got) chk("d_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    d_req = 0;
  endtask

  task automatic p_wait(output logic gi, output logic gd);
    gi = 0;
    gd = 0;
    for (int n = 0; n < 20 && !(gi | gd); n++) begin
      @(negedge clk);
      gi = p_i_ack;
      gd = p_d_ack;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t, ac, ic, dc, t_end;
    logic gi, gd;
    bit seen;
    for (int k = 0; k < 1024; k++) refm[k] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(mem_cs), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_acks", 64'({i_ack, d_ack}), 64'd0);
    bd_clr  = 0;
    bd_we   = 1;
    bd_addr = 10'h80;
    bd_data = 64'h1122334455667788;
    ref_wr(64'h80, 64'h1122334455667788);
    @(negedge clk);
    bd_we = 0;
    rst_n = 1;
    @(posedge clk); #1;

    t = cyc;
    do_i(64'h80, ac);
    chk("i_latency", 64'(ac - t), 64'd2);
    t = cyc;
    do_d(1'b1, 64'h83, 64'hAABBCCDDEEFF0011, ac);
    chk("d_wr_latency", 64'(ac - t), 64'd2);
    do_d(1'b0, 64'h83, 64'h0, ac);

    do_reset();
    t = cyc;
    fork
      do_i(64'h80, ic);
      do_d(1'b0, 64'h83, 64'h0, dc);
    join
    chk("cont_d_first", 64'(dc - t), 64'd2);
    chk("cont_i_after", 64'(ic - dc), 64'd2);

    order_q.delete();
    fork
      for (int r = 0; r < 5; r++) do_i(64'(8 * r + 1), ic);
      for (int r = 0; r < 5; r++) do_d(1'b0, 64'(8 * r), 64'h0, dc);
    join
    chk("rr_count", 64'(order_q.size()), 64'd10);
    for (int k = 0; k < order_q.size(); k++)
      chk("rr_order", 64'(order_q[k]), 64'((k % 2) == 0));

    d_we    = 1;
    d_addr  = 64'h100;
    d_wdata = 64'hDEADBEEFCAFEF00D;
    d_req   = 1;
    seen    = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = mem_cs;
    end
    chk("mid_wr_access", 64'({seen, mem_we}), 64'd3);
    #2;
    rst_n = 0;
    d_req = 0;
    #1;
    chk("mid_wr_cs", 64'(mem_cs), 64'd0);
    chk("mid_wr_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(mem_cs), 64'd0);
    end
    chk("mid_wr_word", ram_rd(64'h100), 64'd0);
    @(posedge clk); #1;

    for (int r = 0; r < 10; r++) begin
      p_i_req = 1;
      p_d_req = 1;
      p_wait(gi, gd);
      chk("fp_d_wins", 64'({gi, gd}), 64'd1);
      p_d_req = 0;
      p_wait(gi, gd);
      chk("fp_i_next", 64'({gi, gd}), 64'd2);
      p_i_req = 0;
      p_d_req = 1;
      p_wait(gi, gd);
      chk("fp_d_solo", 64'({gi, gd}), 64'd1);
      p_d_req = 0;
    end

    // I reads anywhere below 0x200, D owns 0x200-0x3FF
    t_end = cyc + 1000;
    fork
      begin : rnd_i
        int ka, aa;
        while (cyc < t_end) begin
          ka = $urandom_range(0, 3);
          repeat (ka) begin @(posedge clk); #1; end
          do_i({32'($urandom), 32'($urandom_range(0, 'h1F8))}, aa);
        end
      end
      begin : rnd_d
        int kb, ab;
        while (cyc < t_end) begin
          kb = $urandom_range(0, 3);
          repeat (kb) begin @(posedge clk); #1; end
          do_d(1'($urandom),
               {32'($urandom), 32'('h200 + $urandom_range(0, 'h1F0))},
               {32'($urandom), 32'($urandom)}, ab);
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("iq_drained", 64'(iq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);
    chk("acks_vs_reqs", 64'(i_acks + d_acks), 64'(n_iss));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer that shares the single-ported, registered-read test RAM between the instruction-fetch port (port I) and the load/store port (port D). It accepts independent req/ack transactions from each requester and drives the RAM's cs/we/addr/data_in. It holds the address through the RAM's one-cycle read latency, because the RAM's output byte-alignment mux depends on addr[2:0]. It then returns the aligned 64-bit read data with a one-cycle ack pulse.

## Interface
- FIXED_PRI, default 0: 0 = round-robin between I and D on contention; 1 = port D always wins.
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  port I request, held with i_addr stable until i_ack
- i_addr  in  64  port I byte address (any alignment)
- i_ack  out  1  one-cycle pulse: transaction done, i_rdata valid
- i_rdata  out  64  port I read data; 0 when i_ack low
- d_req  in  1  port D request, held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  port D write (1) / read (0)
- d_addr  in  64  port D byte address (any alignment)
- d_wdata  in  64  port D write data
- d_ack  out  1  one-cycle pulse: transaction done
- d_rdata  out  64  port D read data for reads; 0 for writes and when d_ack low
- mem_cs  out  1  RAM chip select (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  64  RAM address (registered, held through RESP)
- mem_wdata  out  64  RAM write data (registered)
- mem_rdata  in  64  RAM data_out (aligned, valid in cycle after cs)

## Operation
- The FSM has three states.
  - IDLE: arbitrate. If any eligible request is pending, load mem_* from the winner, set mem_cs=1 and mem_we=winner's we, record the owner, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_cs=1 for exactly this cycle. The RAM captures the read at the end of this cycle, or performs the write at the end of this cycle. Next state is RESP, with mem_cs and mem_we cleared and mem_addr held.
  - RESP: ack the owner combinationally from the state. rdata = mem_rdata for reads and 0 for writes. Arbitrate as in IDLE, with the owner masked. If another request is pending, go to ACCESS with new mem_* values; else go to IDLE.
- The owner is masked in RESP because its req is still high in its ack cycle. A requester may re-assert req the cycle after its ack.
- Round-robin (FIXED_PRI=0): a last_grant bit (reset value = I) records the most recent winner. On contention, the port that is not last_grant wins.
- With FIXED_PRI=1, D always wins contention, and port I can starve under continuous D traffic.
- mem_addr and mem_wdata pass unchanged, with no alignment check. Unaligned and word-straddling accesses are the RAM's concern.
- Only one ack is asserted per cycle. i_ack and d_ack are never high together.
- Reset (asynchronous, any state): the FSM goes to IDLE. mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, last_grant=I, and both acks are 0.
  - A transaction interrupted by reset is dropped and never acked.
  - A write in ACCESS when reset asserts must not be committed: mem_cs and mem_we clear asynchronously.

## Timing
- Request sampled at edge N (in IDLE): ACCESS during cycle N+1, ack during cycle N+2. Latency is 2 cycles from the sampling edge to ack.
- Back-to-back pending requests give one transaction per 2 cycles (ACCESS, RESP, ACCESS, RESP...).
- mem_cs is never high in two consecutive cycles.
- mem_addr is stable from ACCESS through the end of RESP.
- A request arriving while the FSM is in ACCESS is sampled at the next arbitration point (RESP).
- A req that drops before its ack is a protocol violation, and behaviour is unspecified.

## Test plan
- Single I read: preload RAM word 0x10 = 0x1122334455667788; i_req with i_addr=0x80 -> mem_cs high for 1 cycle, i_ack 2 cycles after sampling, i_rdata=0x1122334455667788.
- D write then read, unaligned: d_we=1, d_addr=0x83, d_wdata=0xAABBCCDDEEFF0011, ack. Then d_we=0, d_addr=0x83 -> d_ack with d_rdata=0xAABBCCDDEEFF0011 and write-cycle d_rdata=0.
- Contention, round-robin: i_req and d_req asserted together from reset -> D served first (last_grant=I), I acked exactly 2 cycles after D's ack, mem_cs pattern 1,0,1,0.
- Continuous contention with FIXED_PRI=1: D re-requests right after each ack for 10 transactions -> I never acked. With FIXED_PRI=0, grants strictly alternate.
- Reset mid-write: assert rst_n=0 during ACCESS of a D write to 0x100 (old value 0x0) -> mem_cs/mem_we drop immediately, word 0x100 still 0x0, no ack, FSM in IDLE after release.
- Ack exclusivity: random req traffic for 1000 cycles -> never i_ack & d_ack, never mem_cs in consecutive cycles, every req acked exactly once.
